instruction_fetch_sequencer: RTL and testbench
==============================================

# instruction_fetch_sequencer

Two-byte instruction fetch controller that drives the address register file's control inputs and the byte-wide memory read strobe. It selects PC onto the memory address output (OutD), reads the instruction low byte then high byte into IR, and increments PC after each byte. It sits directly upstream of the address register file, between the main control unit (request/done handshake) and the ARF/memory/IR control pins.

## Interface

Parameters:
- WAIT_CYCLES, 0: extra memory wait cycles per byte read (0..15). Honoured only with FETCH_WAIT_EN.

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock
- FetchReq  in  1  fetch request from control unit; sampled only in IDLE
- Busy  out  1  high in every state except IDLE
- FetchDone  out  1  one-cycle pulse after the high byte is written
- ARF_OutDSel  out  2  ARF OutD select; always 2'b00 (PC)
- ARF_RegSel  out  3  ARF register enables, active-low, {PC,AR,SP}
- ARF_FunSel  out  3  ARF function; 3'b001 = increment, 3'b000 otherwise
- Mem_CS  out  1  memory chip select, active-low
- Mem_WR  out  1  memory write enable; always 0 (read)
- IR_Write  out  1  IR byte write enable, active-high
- IR_LH  out  1  IR half select: 0 = low byte, 1 = high byte

## Operation

- States: IDLE, FETCH_LO, FETCH_HI, DONE. 2-bit state register.
- IDLE: Busy=0, Mem_CS=1, IR_Write=0, ARF_RegSel=3'b111, ARF_FunSel=3'b000, FetchDone=0. FetchReq=1 -> FETCH_LO.
- FETCH_LO: Mem_CS=0, IR_LH=0. On the final cycle of the byte: IR_Write=1, ARF_RegSel=3'b011, ARF_FunSel=3'b001 (PC+1 on that edge); -> FETCH_HI.
- FETCH_HI: same as FETCH_LO with IR_LH=1; final cycle -> DONE.
- DONE: FetchDone=1, Mem_CS=1, Busy=1, no register or IR write; -> IDLE unconditionally.
- Non-final (wait) cycles: Mem_CS=0, IR_Write=0, ARF_RegSel=3'b111; PC and IR unchanged.
- ARF_OutDSel=2'b00 and Mem_WR=0 in all states, including reset.
- FetchReq outside IDLE ignored; no queuing. FetchReq held high gives back-to-back fetches, one IDLE cycle between them.
- PC wrap-around (16'hFFFF + 1 = 16'h0000) is performed by the ARF; no detection here.
- All outputs are decoded from the state and wait counter (Moore); no combinational path from FetchReq.

## Timing

- Reset=1 at an edge: state -> IDLE, wait counter -> 0; all outputs take IDLE values the following cycle. Reset dominates FetchReq.
- Reset mid-fetch: abort at that edge. PC is incremented only if the increment cycle had already completed at an earlier edge. No FetchDone pulse.
- Byte latency: WAIT_CYCLES+1 cycles per byte. Wait counter width 4, loaded with 0 on state entry, compared against WAIT_CYCLES.
- Fetch latency, FetchReq sampled -> FetchDone high: 2*(WAIT_CYCLES+1)+1 cycles. Minimum request period with continuous FetchReq: 2*(WAIT_CYCLES+1)+2 cycles.
- PC value presented during FETCH_HI is the original PC+1. After DONE, PC equals the original PC+2.

## Configuration

- FETCH_WAIT_EN defined: wait counter compiled in; each byte holds Mem_CS=0 for WAIT_CYCLES+1 cycles as above.
- FETCH_WAIT_EN undefined: no counter. Every byte is single-cycle and WAIT_CYCLES is ignored. Fetch latency is fixed at 3 cycles; period is 4 cycles with FetchReq held.

## Test plan

- Reset, WAIT_CYCLES=0, with a behavioural ARF and memory: PC=16'h0010, mem[0x10]=8'hA5, mem[0x11]=8'h3C, pulse FetchReq -> IR=16'h3CA5, PC=16'h0012, FetchDone high exactly 3 cycles after the sampling edge.
- FetchReq held high for 12 cycles from PC=16'h0000 -> exactly 3 FetchDone pulses 4 cycles apart; PC=16'h0006.
- PC=16'hFFFF -> low byte read from 0xFFFF, high byte from 0x0000; final PC=16'h0001.
- Reset asserted on the FETCH_HI cycle with PC=16'h0020 -> next cycle IDLE, Mem_CS=1, no FetchDone; PC=16'h0021, IR high byte unchanged.
- FETCH_WAIT_EN with WAIT_CYCLES=2 -> Mem_CS low 3 cycles per byte. IR_Write and ARF_RegSel=3'b011 only on the 3rd cycle of each byte; FetchDone 7 cycles after the request.
- FetchReq pulsed during FETCH_LO and DONE -> ignored; exactly one fetch occurs.

Source files
------------

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch sequencer: PC -> memory -> IR, PC+1 per byte.
// Optional per-byte wait states are compiled in with `define FETCH_WAIT_EN.
module instruction_fetch_sequencer #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       FetchReq,
  output logic       Busy,
  output logic       FetchDone,
  output logic [1:0] ARF_OutDSel,
  output logic [2:0] ARF_RegSel,
  output logic [2:0] ARF_FunSel,
  output logic       Mem_CS,
  output logic       Mem_WR,
  output logic       IR_Write,
  output logic       IR_LH
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   in_fetch;
  logic   last_byte;
  logic   fire;

  assign in_fetch = (state_q == FETCH_LO) ||
                    (state_q == FETCH_HI);

`ifdef FETCH_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [3:0] wait_q, wait_d;

  assign last_byte = (wait_q == WAIT_LAST);

  // Wait counter: counts up while a byte is stalled, zero otherwise
  always_comb begin
    wait_d = '0;
    if (in_fetch && !last_byte)
      wait_d = wait_q + 4'd1;
  end

  // Wait counter register
  always_ff @(posedge Clock) begin
    if (Reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  logic unused_wait;

  assign unused_wait = ^WAIT_CYCLES;
  assign last_byte   = 1'b1;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; FetchReq only matters in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (FetchReq)  state_d = FETCH_LO;
      FETCH_LO: if (last_byte) state_d = FETCH_HI;
      FETCH_HI: if (last_byte) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Byte strobes are masked while Reset is high so an aborted
  // fetch never commits a PC increment or IR write on that edge
  assign fire = in_fetch && last_byte && !Reset;

  // Output decode from state and wait counter
  always_comb begin
    Busy        = (state_q != IDLE);
    FetchDone   = (state_q == DONE);
    ARF_OutDSel = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = !in_fetch;
    IR_LH       = (state_q == FETCH_HI);
    IR_Write    = fire;
    ARF_RegSel  = fire ? 3'b011 : 3'b111;
    ARF_FunSel  = fire ? 3'b001 : 3'b000;
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer with behavioural ARF (PC),
// byte memory and IR; expected fetch results flow through a scoreboard.
module tb_instruction_fetch_sequencer;

`ifdef FETCH_WAIT_EN
  localparam int BYTE = 3;
`else
  localparam int BYTE = 1;
`endif
  localparam int LAT = 2 * BYTE + 1;
  localparam int PER = 2 * BYTE + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       Busy, FetchDone, Mem_CS, Mem_WR;
  logic       IR_Write, IR_LH;
  logic [1:0] OutDSel;
  logic [2:0] RegSel, FunSel;

  logic [15:0] pc, ir;
  logic [7:0]  mem [0:65535];
  logic        pc_ld, ir_ld;
  logic [15:0] pc_ld_v, ir_ld_v;
  logic [15:0] addr;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  instruction_fetch_sequencer #(.WAIT_CYCLES(2)) dut (
    .Clock(clk), .Reset(rst), .FetchReq(req),
    .Busy(Busy), .FetchDone(FetchDone),
    .ARF_OutDSel(OutDSel), .ARF_RegSel(RegSel),
    .ARF_FunSel(FunSel), .Mem_CS(Mem_CS),
    .Mem_WR(Mem_WR), .IR_Write(IR_Write), .IR_LH(IR_LH)
  );

  always #5 clk = ~clk;

  assign addr = (OutDSel == 2'b00) ? pc : 16'h0000;

  always @(posedge clk) begin
    if (pc_ld)
      pc <= pc_ld_v;
    else if (!RegSel[2] && FunSel == 3'b001)
      pc <= pc + 16'd1;
    if (ir_ld)
      ir <= ir_ld_v;
    else if (IR_Write && !Mem_CS) begin
      if (IR_LH) ir[15:8] <= mem[addr];
      else       ir[7:0]  <= mem[addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_ld = 1'b1; pc_ld_v = v;
    tick();
    pc_ld = 1'b0;
  endtask

  task automatic set_ir(input logic [15:0] v);
    ir_ld = 1'b1; ir_ld_v = v;
    tick();
    ir_ld = 1'b0;
  endtask

  // Issue one request and follow it to FetchDone, gathering observations
  task automatic run_fetch(output int lat, output int cs_lo,
                           output int irw, output int bad,
                           output logic [15:0] a_lo,
                           output logic [15:0] a_hi,
                           output bit ok);
    lat = 1; cs_lo = 0; irw = 0; bad = 0;
    a_lo = 16'hxxxx; a_hi = 16'hxxxx;
    req = 1'b1;
    tick();
    req = 1'b0;
    while (!FetchDone && lat < 64) begin
      if (!Mem_CS) cs_lo++;
      if (IR_Write) begin
        irw++;
        if (IR_LH) a_hi = addr;
        else       a_lo = addr;
        if (RegSel !== 3'b011 || FunSel !== 3'b001) bad++;
      end else if (RegSel !== 3'b111 || FunSel !== 3'b000) begin
        bad++;
      end
      tick();
      lat++;
    end
    ok = FetchDone;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1;
    tick();
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_dominates: Busy=%b want 0", Busy);
    end
    tick();
    rst = 1'b0; req = 1'b0;
    tests++;
    if (Mem_CS !== 1'b1 || FetchDone !== 1'b0 || IR_Write !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: cs=%b done=%b irw=%b want 1 0 0",
               Mem_CS, FetchDone, IR_Write);
    end
    tests++;
    if (RegSel !== 3'b111 || FunSel !== 3'b000) begin
      fails++;
      $display("FAIL reset_arf: regsel=%b funsel=%b want 111 000",
               RegSel, FunSel);
    end
    tests++;
    if (OutDSel !== 2'b00 || Mem_WR !== 1'b0) begin
      fails++;
      $display("FAIL reset_fixed: outdsel=%b wr=%b want 00 0",
               OutDSel, Mem_WR);
    end
  endtask

  task automatic test_basic;
    int lat, cs_lo, irw, bad;
    logic [15:0] a_lo, a_hi;
    bit ok;
    exp_t e;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    set_pc(16'h0010);
    set_ir(16'h0000);
    sb.push_back('{ir: 16'h3CA5, pc: 16'h0012});
    run_fetch(lat, cs_lo, irw, bad, a_lo, a_hi, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_timeout: no FetchDone in %0d cycles", lat);
    end
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    end
    tests++;
    if (cs_lo !== 2 * BYTE || irw !== 2) begin
      fails++;
      $display("FAIL basic_cs_irw: cs_lo=%0d irw=%0d want %0d 2",
               cs_lo, irw, 2 * BYTE);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL basic_arf_strobe: %0d bad cycles want 0", bad);
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL basic_sb: queue empty want 1 entry");
    end else begin
      e = sb.pop_front();
      if (ir !== e.ir || pc !== e.pc) begin
        fails++;
        $display("FAIL basic_result: ir=%h pc=%h want %h %h",
                 ir, pc, e.ir, e.pc);
      end
    end
    tick();
    tests++;
    if (Busy !== 1'b0 || FetchDone !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: busy=%b done=%b want 0 0",
               Busy, FetchDone);
    end
  endtask

  task automatic test_back_to_back;
    int n, dn, last, gap_bad, res_bad;
    exp_t e;
    n = (12 + PER - 1) / PER;
    for (int k = 0; k < 6; k++) mem[k] = 8'(8'h10 + k);
    set_pc(16'h0000);
    for (int k = 0; k < n; k++)
      sb.push_back('{ir: {mem[2*k+1], mem[2*k]},
                     pc: 16'(2 * k + 2)});
    dn = 0; last = 0; gap_bad = 0; res_bad = 0;
    for (int c = 0; c < 40; c++) begin
      req = (c < 12);
      tick();
      if (FetchDone) begin
        if (dn > 0 && c - last != PER) gap_bad++;
        last = c;
        dn++;
        if (sb.size() == 0) res_bad++;
        else begin
          e = sb.pop_front();
          if (ir !== e.ir || pc !== e.pc) res_bad++;
        end
      end
    end
    req = 1'b0;
    tests++;
    if (dn !== n) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses want %0d", dn, n);
    end
    tests++;
    if (gap_bad !== 0) begin
      fails++;
      $display("FAIL b2b_period: %0d bad gaps want 0 (period %0d)",
               gap_bad, PER);
    end
    tests++;
    if (res_bad !== 0 || sb.size() !== 0) begin
      fails++;
      $display("FAIL b2b_result: %0d bad, %0d left want 0 0",
               res_bad, sb.size());
    end
    tests++;
    if (pc !== 16'(2 * n)) begin
      fails++;
      $display("FAIL b2b_pc: got %h want %h", pc, 16'(2 * n));
    end
  endtask

  task automatic test_pc_wrap;
    int lat, cs_lo, irw, bad;
    logic [15:0] a_lo, a_hi;
    bit ok;
    exp_t e;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    set_pc(16'hFFFF);
    sb.push_back('{ir: 16'h2211, pc: 16'h0001});
    run_fetch(lat, cs_lo, irw, bad, a_lo, a_hi, ok);
    tests++;
    if (!ok || a_lo !== 16'hFFFF || a_hi !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_addr: ok=%0d lo=%h hi=%h want 1 ffff 0000",
               ok, a_lo, a_hi);
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL wrap_sb: queue empty want 1 entry");
    end else begin
      e = sb.pop_front();
      if (ir !== e.ir || pc !== e.pc) begin
        fails++;
        $display("FAIL wrap_result: ir=%h pc=%h want %h %h",
                 ir, pc, e.ir, e.pc);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int guard, dn;
    mem[16'h0020] = 8'h77;
    mem[16'h0021] = 8'h99;
    set_pc(16'h0020);
    set_ir(16'hBEEF);
    req = 1'b1;
    tick();
    req = 1'b0;
    guard = 0;
    while (!(!Mem_CS && IR_LH) && guard < 64) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 64) begin
      fails++;
      $display("FAIL rstmid_reach_hi: FETCH_HI not seen in 64 cycles");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (Busy !== 1'b0 || Mem_CS !== 1'b1 || FetchDone !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: busy=%b cs=%b done=%b want 0 1 0",
               Busy, Mem_CS, FetchDone);
    end
    tests++;
    if (pc !== 16'h0021 || ir !== 16'hBE77) begin
      fails++;
      $display("FAIL rstmid_regs: pc=%h ir=%h want 0021 be77", pc, ir);
    end
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (FetchDone) dn++;
    end
    tests++;
    if (dn !== 0) begin
      fails++;
      $display("FAIL rstmid_nodone: got %0d pulses want 0", dn);
    end
  endtask

  task automatic test_ignore_req;
    int dn, res_bad;
    exp_t e;
    mem[16'h0040] = 8'h5A;
    mem[16'h0041] = 8'hC3;
    set_pc(16'h0040);
    sb.push_back('{ir: 16'hC35A, pc: 16'h0042});
    req = 1'b1;
    tick();
    dn = 0; res_bad = 0;
    for (int c = 0; c < 30; c++) begin
      req = Busy && ((!Mem_CS && !IR_LH) || FetchDone);
      tick();
      if (FetchDone) begin
        dn++;
        if (sb.size() == 0) res_bad++;
        else begin
          e = sb.pop_front();
          if (ir !== e.ir || pc !== e.pc) res_bad++;
        end
      end
    end
    req = 1'b0;
    tests++;
    if (dn !== 1 || res_bad !== 0) begin
      fails++;
      $display("FAIL ignore_req: pulses=%0d bad=%0d want 1 0",
               dn, res_bad);
    end
    tests++;
    if (pc !== 16'h0042) begin
      fails++;
      $display("FAIL ignore_pc: got %h want 0042", pc);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0;
    pc_ld = 1'b0; pc_ld_v = '0;
    ir_ld = 1'b0; ir_ld_v = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid();
    test_ignore_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
